// File: rtl/arb_pkg.sv
// Shared constants, state encoding and helpers for the 4-way round-robin arbiter.
package arb_pkg;

  localparam int N_REQ  = 4;
  localparam int IDX_W  = 2;
  localparam int HOLD_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // One-hot decode of a requester index; keeps gnt and gnt_idx consistent by construction.
  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arbiter_4_if;
  import arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic             done;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             timeout;

  modport slave (
    input  req, done,
    output gnt, gnt_idx, gnt_valid, timeout
  );

  modport master (
    output req, done,
    input  gnt, gnt_idx, gnt_valid, timeout
  );

endinterface

// File: rtl/prio_enc_4to2.sv
// Lowest-set-bit priority encoder over the pointer-rotated request vector.
// Bit 0 of req_rot is the requester the round-robin pointer currently favours.
module prio_enc_4to2
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req_rot,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the top down so the lowest set bit is the last (winning) assignment.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a bounded hold time per grant.
// Every output comes straight from a flop; a release always inserts one IDLE cycle.
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 15
)
(
  input logic           clk,
  input logic           rst,
  rr_arbiter_4_if.slave bus
);

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    ptr_reg, ptr_next;
  logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next;
  logic [N_REQ-1:0]    gnt_reg, gnt_next;
  logic [IDX_W-1:0]    gnt_idx_reg, gnt_idx_next;
  logic                gnt_valid_reg, gnt_valid_next;
  logic                timeout_reg, timeout_next;

  logic [N_REQ-1:0]    req_rot;
  logic [IDX_W-1:0]    rot_sel [N_REQ];
  logic [IDX_W-1:0]    enc_idx;
  logic                enc_valid;
  logic [IDX_W-1:0]    win_idx;
  logic                at_limit;
  logic                req_drop;

  // Rotate requests so the requester at ptr lands on bit 0 of the encoder input.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_rot
      assign rot_sel[gi] = IDX_W'(gi) + ptr_reg;
      assign req_rot[gi] = bus.req[rot_sel[gi]];
    end
  endgenerate

  prio_enc_4to2 u_prio (
    .req_rot (req_rot),
    .idx     (enc_idx),
    .valid   (enc_valid)
  );

  // Undo the rotation: modulo-4 add wraps naturally in IDX_W bits.
  assign win_idx  = enc_idx + ptr_reg;
  assign at_limit = (hold_cnt_reg == HOLD_W'(MAX_HOLD - 1));
  assign req_drop = ~bus.req[gnt_idx_reg];

  // Next-state and registered-output logic for the IDLE/GRANT machine.
  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    hold_cnt_next  = hold_cnt_reg;
    gnt_next       = gnt_reg;
    gnt_idx_next   = gnt_idx_reg;
    gnt_valid_next = gnt_valid_reg;
    timeout_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (enc_valid) begin
          state_next     = GRANT;
          gnt_idx_next   = win_idx;
          gnt_next       = idx_to_onehot(win_idx);
          gnt_valid_next = 1'b1;
          hold_cnt_next  = '0;
        end
      end
      GRANT: begin
        if (bus.done || req_drop || at_limit) begin
          state_next     = IDLE;
          ptr_next       = gnt_idx_reg + 1'b1;
          gnt_next       = '0;
          gnt_idx_next   = '0;
          gnt_valid_next = 1'b0;
          // Only a release forced purely by the hold limit is reported.
          timeout_next   = at_limit && !bus.done && !req_drop;
        end else begin
          hold_cnt_next  = hold_cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next     = IDLE;
        gnt_next       = '0;
        gnt_idx_next   = '0;
        gnt_valid_next = 1'b0;
      end
    endcase
  end

  // State and output registers; reset overrides everything, including a live grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      hold_cnt_reg  <= '0;
      gnt_reg       <= '0;
      gnt_idx_reg   <= '0;
      gnt_valid_reg <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      hold_cnt_reg  <= hold_cnt_next;
      gnt_reg       <= gnt_next;
      gnt_idx_reg   <= gnt_idx_next;
      gnt_valid_reg <= gnt_valid_next;
      timeout_reg   <= timeout_next;
    end
  end

  assign bus.gnt       = gnt_reg;
  assign bus.gnt_idx   = gnt_idx_reg;
  assign bus.gnt_valid = gnt_valid_reg;
  assign bus.timeout   = timeout_reg;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench for rr_arbiter_4 (MAX_HOLD=4): a vector table plus hand-written
// multi-cycle sequences, with expected outputs queued at drive time and popped after the edge.
module tb_rr_arbiter_4;

  logic clk = 1'b0;
  logic rst;

  rr_arbiter_4_if bus ();

  rr_arbiter_4 #(.MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       valid;
    logic       to;
  } exp_t;

  typedef struct packed {
    logic       rst;
    logic [3:0] req;
    logic       done;
    exp_t       exp;
  } vec_t;

  exp_t  sb [$];
  vec_t  vecs [$];
  string vnames [$];
  int    checks = 0;
  int    errors = 0;

  // Drive one cycle of inputs, queue the expected post-edge outputs, then compare after the edge.
  task automatic step(input logic rs, input logic [3:0] r, input logic d,
                      input logic [3:0] eg, input logic [1:0] ei, input logic ev,
                      input logic et, input string name);
    exp_t e;
    exp_t got;
    rst      = rs;
    bus.req  = r;
    bus.done = d;
    e = '{gnt: eg, idx: ei, valid: ev, to: et};
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = '{gnt: bus.gnt, idx: bus.gnt_idx, valid: bus.gnt_valid, to: bus.timeout};
    e = sb.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s: got gnt=%b idx=%0d valid=%b timeout=%b, want gnt=%b idx=%0d valid=%b timeout=%b",
               name, got.gnt, got.idx, got.valid, got.to, e.gnt, e.idx, e.valid, e.to);
    end else begin
      $display("ok   %s: gnt=%b idx=%0d valid=%b timeout=%b", name, got.gnt, got.idx, got.valid, got.to);
    end
  endtask

  function automatic void add(input logic rs, input logic [3:0] r, input logic d,
                              input logic [3:0] eg, input logic [1:0] ei, input logic ev,
                              input logic et, input string name);
    vec_t v;
    v.rst  = rs;
    v.req  = r;
    v.done = d;
    v.exp  = '{gnt: eg, idx: ei, valid: ev, to: et};
    vecs.push_back(v);
    vnames.push_back(name);
  endfunction

  initial begin
    rst      = 1'b1;
    bus.req  = 4'b0000;
    bus.done = 1'b0;

    //   rst  req      done  gnt      idx   v     to
    // Reset held with all requests up, then first grant to requester 0.
    add(1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "reset_1");
    add(1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "reset_2");
    // Rotation 0,1,2,3,0 with done one cycle after each grant.
    add(1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "rot_g0");
    add(1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "rot_rel0");
    add(1'b0, 4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, "rot_g1");
    add(1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "rot_rel1");
    add(1'b0, 4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, "rot_g2");
    add(1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "rot_rel2");
    add(1'b0, 4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, "rot_g3");
    add(1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "rot_rel3");
    add(1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "rot_g0_again");
    add(1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "rot_rel0_again");
    // Idle with no requests; done in IDLE must do nothing.
    add(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "idle_done_ignored");
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "idle_quiet");
    // Pointer skip: grant 1, then only req0 -> wraps to 0; grant 3 twice with ptr=0.
    add(1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, "skip_g1");
    add(1'b0, 4'b0010, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "skip_rel1");
    add(1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "skip_wrap_g0");
    add(1'b0, 4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "skip_rel0");
    add(1'b0, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, "skip_g3");
    add(1'b0, 4'b1000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "skip_rel3");
    add(1'b0, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, "skip_g3_again");
    add(1'b0, 4'b1000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "skip_rel3_again");
    // Grant held while other req bits toggle; done coincides with the hold limit -> no timeout.
    add(1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "hold_g0");
    add(1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "hold_others_1");
    add(1'b0, 4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "hold_others_2");
    add(1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "hold_others_3");
    add(1'b0, 4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "limit_with_done");

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].done, vecs[i].exp.gnt, vecs[i].exp.idx,
           vecs[i].exp.valid, vecs[i].exp.to, vnames[i]);
    end

    // Timeout: req2 held, done low -> 4 grant cycles, timeout pulse in the IDLE gap, re-grant.
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, $sformatf("to_hold_%0d", k));
    end
    step(1'b0, 4'b0100, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, "to_pulse");
    step(1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, "to_regrant");

    // Request drop in the third grant cycle -> release, no timeout, ptr=3.
    step(1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, "drop_cycle2");
    step(1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, "drop_cycle3");
    step(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "drop_release");
    step(1'b0, 4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, "drop_ptr3");
    step(1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "drop_rel3");

    // Mid-grant reset while granting 3, then req=1010 -> grant 1.
    step(1'b0, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, "mrst_g3");
    step(1'b1, 4'b1010, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "mrst_drop");
    step(1'b0, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, "mrst_first_g1");
    step(1'b0, 4'b1010, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "mrst_rel1");
    // ptr is now 2; reset in IDLE must bring it back to 0.
    step(1'b1, 4'b1010, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "rst_idle");
    step(1'b0, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, "rst_ptr0_g1");
    // Reset exactly at the hold limit: grant drops with no timeout pulse.
    step(1'b0, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, "rlim_hold1");
    step(1'b0, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, "rlim_hold2");
    step(1'b0, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, "rlim_hold3");
    step(1'b1, 4'b1010, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "rlim_reset");
    step(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "rlim_quiet");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
